mix_col_iter: RTL

- Sequential, parametrised successor to the combinational MixColumns stage: one 128-bit AES state per transaction, valid/ready handshake on both sides.
- Optionally fuses ShiftRows. Supports forward MixColumns and (optionally) InvMixColumns, selected per transaction.
- Processes COLS_PER_CYCLE columns per clock, trading area against latency.
- Sits between the S-box stage and AddRoundKey in the round datapath; shared by the encrypt and decrypt paths.

---
 rtl/mix_col_iter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mix_col_iter.sv
// ==== mix_col_iter: iterative (Inv)MixColumns with optional fused (Inv)ShiftRows ====
// Rev 1.0
`default_nettype none

module mix_col_iter #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1,
  parameter bit SHIFT_EN       = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic         mode_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data
);

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_col_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant via shift-and-add over GF(2^8).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Column word holds row 0 in the top byte; row r uses the base row rotated right by r.
  function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
    logic [7:0]  a [4];
    logic [3:0]  k [4];
    logic [7:0]  acc;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
    if (inv) begin
      k[0] = 4'he; k[1] = 4'hb; k[2] = 4'hd; k[3] = 4'h9;
    end else begin
      k[0] = 4'h2; k[1] = 4'h3; k[2] = 4'h1; k[3] = 4'h1;
    end
    r = '0;
    for (int row = 0; row < 4; row++) begin
      acc = '0;
      for (int i = 0; i < 4; i++) acc = acc ^ gmul(a[(row + i) % 4], k[i]);
      r[31-8*row -: 8] = acc;
    end
    return r;
  endfunction

  // Byte k of a flat state sits at [127-8k -: 8]; byte (c,r) is k = 4c+r.
  function automatic logic [127:0] permute_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int           sc;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*sc+r) -: 8];
      end
    end
    return o;
  endfunction

  logic [1:0]   state;
  logic [1:0]   state_nx;
  logic [1:0]   cnt;
  logic         mode_r;
  logic [31:0]  src [4];
  logic [31:0]  res [4];
  logic [127:0] in_flat;
  logic [127:0] in_loaded;
  logic [127:0] res_flat;
  logic [127:0] out_flat;
  logic         mode_eff;
  logic         accept;
  logic [1:0]   lane_idx [COLS_PER_CYCLE];
  logic [31:0]  lane_out [COLS_PER_CYCLE];

  assign in_flat   = in_data;
  assign mode_eff  = INV_EN && mode_in;
  assign accept    = in_valid && in_ready;
  // Forward ShiftRows is folded in at load time so the lanes only see whole columns.
  assign in_loaded = (SHIFT_EN && !mode_eff) ? permute_rows(in_flat, 1'b0) : in_flat;

  generate
    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
      assign lane_idx[j] = cnt + 2'(j);
      assign lane_out[j] = mix_column(src[lane_idx[j]], mode_r);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_BUSY;
      S_BUSY:  if (cnt == LAST_CNT) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mode_r <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        src[c] <= '0;
        res[c] <= '0;
      end
    end else if (state == S_IDLE) begin
      if (accept) begin
        cnt    <= '0;
        mode_r <= mode_eff;
        for (int c = 0; c < 4; c++) src[c] <= in_loaded[127-32*c -: 32];
      end
    end else if (state == S_BUSY) begin
      for (int j = 0; j < COLS_PER_CYCLE; j++) res[lane_idx[j]] <= lane_out[j];
      cnt <= cnt + STEP;
    end
  end

  always_comb begin
    res_flat = '0;
    for (int c = 0; c < 4; c++) res_flat[127-32*c -: 32] = res[c];
  end

  // InvShiftRows is pure wiring on the registered result.
  assign out_flat = (SHIFT_EN && mode_r) ? permute_rows(res_flat, 1'b1) : res_flat;
  assign out_data = out_flat;

endmodule

`default_nettype wire
